// File: rtl/ysyx_22050612_pkg.sv
// Shared constants for the ysyx_22050612 sequencing controller:
// state encoding, halt codes and the ebreak encoding.
package ysyx_22050612_pkg;

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StFetch  = 3'd1;
   localparam logic [2:0] StDecode = 3'd2;
   localparam logic [2:0] StExec   = 3'd3;
   localparam logic [2:0] StMem    = 3'd4;
   localparam logic [2:0] StWb     = 3'd5;
   localparam logic [2:0] StHalt   = 3'd6;

   localparam logic [1:0] HaltNone    = 2'd0;
   localparam logic [1:0] HaltEbreak  = 2'd1;
   localparam logic [1:0] HaltIllegal = 2'd2;
   localparam logic [1:0] HaltTimeout = 2'd3;

   localparam logic [31:0] EBREAK = 32'h00100073;

endpackage

// File: rtl/ysyx_22050612_wait_timer.sv
// Bus wait counter: cleared on entry to a waiting state, counts ack-less cycles
// and flags expiry on the cycle the count would reach TIMEOUT without an ack.
module ysyx_22050612_wait_timer #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic active,
   input  logic ack,
   output logic expired
);

   localparam logic [15:0] Limit = 16'(TIMEOUT - 1);

   logic [15:0] cnt_q, cnt_d;

   // An ack in the final cycle suppresses expiry.
   assign expired = active && !ack && (cnt_q == Limit);

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = 16'd0;
      end else if (active && !ack) begin
         cnt_d = cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 16'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ysyx_22050612_ctrl_fsm.sv
// Multi-cycle sequencing controller: fetch, decode, exec, optional mem, writeback,
// with halt on ebreak, illegal encoding or bus timeout.
module ysyx_22050612_ctrl_fsm
   import ysyx_22050612_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inst_ack,
   input  logic [31:0] inst_rdata,
   input  logic        dec_load,
   input  logic        dec_store,
   input  logic        dec_ebreak,
   input  logic        dec_illegal,
   input  logic        data_ack,
   output logic        inst_req,
   output logic [31:0] ir,
   output logic        data_req,
   output logic        data_we,
   output logic        reg_we,
   output logic        pc_we,
   output logic        halt,
   output logic [1:0]  halt_code,
   output logic [63:0] retired,
   output logic [2:0]  state
);

   logic [2:0]  state_q, state_d;
   logic [1:0]  code_q, code_d;
   logic [31:0] ir_q;
   logic [63:0] retired_q;
   logic        store_q;

   logic waiting;
   logic bus_ack;
   logic tmr_clear;
   logic expired;

   assign waiting   = (state_q == StFetch) || (state_q == StMem);
   assign bus_ack   = (state_q == StFetch) ? inst_ack : data_ack;
   assign tmr_clear = ((state_d == StFetch) && (state_q != StFetch)) ||
                      ((state_d == StMem) && (state_q != StMem));

   ysyx_22050612_wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (tmr_clear),
      .active  (waiting),
      .ack     (bus_ack),
      .expired (expired)
   );

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      case (state_q)
         StIdle: state_d = StFetch;
         StFetch: begin
            if (inst_ack) begin
               state_d = StDecode;
            end else if (expired) begin
               state_d = StHalt;
               code_d  = HaltTimeout;
            end
         end
         StDecode: begin
            if (dec_ebreak) begin
               state_d = StHalt;
               code_d  = HaltEbreak;
            end else if (dec_illegal) begin
               state_d = StHalt;
               code_d  = HaltIllegal;
            end else begin
               state_d = StExec;
            end
         end
         StExec: state_d = (dec_load || dec_store) ? StMem : StWb;
         StMem: begin
            if (data_ack) begin
               state_d = StWb;
            end else if (expired) begin
               state_d = StHalt;
               code_d  = HaltTimeout;
            end
         end
         StWb:   state_d = StFetch;
         StHalt: state_d = StHalt;
         default: begin
            state_d = StIdle;
            code_d  = HaltNone;
         end
      endcase
   end

   // The store class is latched in DECODE so that data_we/reg_we stay pure
   // functions of registered state; load+store together behaves as a store.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         code_q    <= HaltNone;
         ir_q      <= 32'd0;
         retired_q <= 64'd0;
         store_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         if ((state_q == StFetch) && inst_ack) begin
            ir_q <= inst_rdata;
         end
         if (state_q == StDecode) begin
            store_q <= dec_store;
         end
         if (state_q == StWb) begin
            retired_q <= retired_q + 64'd1;
         end
      end
   end

   assign inst_req  = (state_q == StFetch);
   assign data_req  = (state_q == StMem);
   assign data_we   = (state_q == StMem) && store_q;
   assign reg_we    = (state_q == StWb) && !store_q;
   assign pc_we     = (state_q == StWb);
   assign halt      = (state_q == StHalt);
   assign halt_code = code_q;
   assign ir        = ir_q;
   assign retired   = retired_q;
   assign state     = state_q;

endmodule

// File: tb/tb_ysyx_22050612_ctrl_fsm.sv
// Scoreboarded random-program bench for ysyx_22050612_ctrl_fsm with a small
// instruction-class decoder and bus responders modelled in the bench.
module tb_ysyx_22050612_ctrl_fsm;
   import ysyx_22050612_pkg::*;

   localparam int unsigned TO = 4;

   logic        clk, rst_n;
   logic        inst_ack, data_ack;
   logic [31:0] inst_rdata;
   logic        dec_load, dec_store, dec_ebreak, dec_illegal;
   logic        inst_req, data_req, data_we, reg_we, pc_we, halt;
   logic [31:0] ir;
   logic [1:0]  halt_code;
   logic [63:0] retired;
   logic [2:0]  state;

   logic both, force_ill;

   int checks = 0;
   int errors = 0;
   longint unsigned exp_ret = 0;

   typedef struct {
      bit              reg_we;
      bit              data_we;
      int              lat;
      longint unsigned ret;
   } exp_t;
   exp_t sbq[$];

   ysyx_22050612_ctrl_fsm #(
      .TIMEOUT (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .inst_ack    (inst_ack),
      .inst_rdata  (inst_rdata),
      .dec_load    (dec_load),
      .dec_store   (dec_store),
      .dec_ebreak  (dec_ebreak),
      .dec_illegal (dec_illegal),
      .data_ack    (data_ack),
      .inst_req    (inst_req),
      .ir          (ir),
      .data_req    (data_req),
      .data_we     (data_we),
      .reg_we      (reg_we),
      .pc_we       (pc_we),
      .halt        (halt),
      .halt_code   (halt_code),
      .retired     (retired),
      .state       (state)
   );

   // Decoder stand-in: class from opcode; 'both'/'force_ill' create overlap cases.
   assign dec_load    = (ir[6:0] == 7'h03) || both;
   assign dec_store   = (ir[6:0] == 7'h23) || both;
   assign dec_ebreak  = (ir == EBREAK);
   assign dec_illegal = (ir[6:0] == 7'h00) || force_ill;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic wait_req(input bit data);
      int n = 0;
      while (!(data ? data_req : inst_req)) begin
         @(negedge clk);
         n++;
         if (n > 60) begin
            checks++;
            errors++;
            $display("FAIL wait_%s: request never rose", data ? "data_req" : "inst_req");
            return;
         end
      end
   endtask

   task automatic fetch_word(input logic [31:0] w, input int fd);
      wait_req(1'b0);
      repeat (fd) begin
         data_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      data_ack   = 1'b0;
      inst_ack   = 1'b1;
      inst_rdata = w;
      @(negedge clk);
      inst_ack   = 1'b0;
      inst_rdata = $urandom;
   endtask

   task automatic run_inst(input logic [31:0] w, input int fd, input int dd, input bit bth);
      bit st, mem;
      exp_t e;
      st  = (w[6:0] == 7'h23) || bth;
      mem = st || (w[6:0] == 7'h03);
      e.reg_we  = !st;
      e.data_we = st;
      e.lat     = fd + 4 + (mem ? dd + 1 : 0);
      e.ret     = exp_ret;
      sbq.push_back(e);
      exp_ret++;
      wait_req(1'b0);
      both = bth;
      fetch_word(w, fd);
      if (mem) begin
         wait_req(1'b1);
         repeat (dd) begin
            inst_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
         end
         inst_ack = 1'b0;
         data_ack = 1'b1;
         @(negedge clk);
         data_ack = 1'b0;
      end
      both = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      inst_ack  = 1'b0;
      data_ack  = 1'b0;
      both      = 1'b0;
      force_ill = 1'b0;
      repeat (2) @(negedge clk);
      rst_n   = 1'b1;
      exp_ret = 0;
   endtask

   // Monitor: checks every writeback and mem phase against the scoreboard.
   int   cyc = 0;
   bit   in_mem = 1'b0;
   exp_t me;
   always @(negedge clk) begin
      if (!rst_n) begin
         cyc    = 0;
         in_mem = 1'b0;
      end else begin
         if (state >= 3'd1 && state <= 3'd5) cyc++;
         if (data_req && !in_mem && sbq.size() > 0) chk("data_we", data_we, sbq[0].data_we);
         in_mem = data_req;
         if (pc_we) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_empty: pc_we with no pending instruction");
            end else begin
               me = sbq.pop_front();
               chk("wb_reg_we", reg_we, me.reg_we);
               chk("wb_retired", retired, me.ret);
               chk("latency", cyc, me.lat);
            end
            cyc = 0;
         end
      end
   end

   initial begin
      logic [2:0]  seq [6];
      logic [31:0] w;
      int          kind, n;
      bit          stay;

      seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
      rst_n = 1'b0; inst_ack = 1'b0; data_ack = 1'b0; inst_rdata = '0;
      both = 1'b0; force_ill = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_state", state, 0);
      chk("rst_ir", ir, 0);
      chk("rst_retired", retired, 0);
      chk("rst_halt_code", halt_code, 0);
      chk("rst_strobes", {inst_req, data_req, data_we, reg_we, pc_we, halt}, 0);

      // addi with the ack tied high
      inst_ack   = 1'b1;
      inst_rdata = 32'h00100093;
      sbq.push_back('{reg_we: 1'b1, data_we: 1'b0, lat: 4, ret: 0});
      exp_ret = 1;
      rst_n = 1'b1;
      #1 chk("seq0", state, seq[0]);
      for (int i = 1; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("seq%0d", i), state, seq[i]);
         if (i == 2) chk("ir_addi", ir, 32'h00100093);
         if (i == 4) chk("wb_pc_we", pc_we, 1);
      end
      inst_ack = 1'b0;
      chk("retired_addi", retired, 1);

      run_inst(32'h00000013, 3, 0, 1'b0);  // ack on the last legal fetch cycle
      run_inst(32'h0000b083, 0, 3, 1'b0);
      run_inst(32'h0010b023, 0, 0, 1'b0);
      run_inst(32'h0000b083, 1, 1, 1'b1);  // load+store overlap
      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 4);
         w    = $urandom;
         case (kind)
            0:       w[6:0] = 7'h13;
            1:       w[6:0] = 7'h33;
            2:       w[6:0] = 7'h03;
            default: w[6:0] = 7'h23;
         endcase
         run_inst(w, $urandom_range(0, 3), $urandom_range(0, 3), kind == 4);
      end

      fetch_word(EBREAK, $urandom_range(0, 3));
      chk("ebreak_decode_halt", halt, 0);
      @(negedge clk);
      chk("ebreak_halt", halt, 1);
      chk("ebreak_code", halt_code, 1);
      chk("ebreak_retired", retired, exp_ret);
      stay = 1'b1;
      repeat (100) begin
         inst_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (state != 3'd6 || halt_code != 2'd1) stay = 1'b0;
      end
      inst_ack = 1'b0;
      chk("halt_absorbing", stay, 1);
      chk("sb_drained", sbq.size(), 0);

      do_reset();
      fetch_word(32'h00000000, 2);
      @(negedge clk);
      chk("illegal_halt", halt, 1);
      chk("illegal_code", halt_code, 2);

      do_reset();
      force_ill = 1'b1;
      fetch_word(EBREAK, 1);
      @(negedge clk);
      chk("ebreak_over_illegal", halt_code, 1);

      do_reset();
      wait_req(1'b0);
      n = 0;
      while (state == 3'd1 && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("timeout_cycles", n, TO);
      chk("timeout_state", state, 6);
      chk("timeout_code", halt_code, 3);

      do_reset();
      run_inst(32'h00000013, 0, 0, 1'b0);
      run_inst(32'h00000033, 1, 0, 1'b0);
      fetch_word(32'h0000b083, 0);
      wait_req(1'b1);
      @(negedge clk);
      chk("pre_rst_retired", retired, 2);
      chk("pre_rst_data_req", data_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midmem_data_req", data_req, 0);
      chk("midmem_state", state, 0);
      chk("midmem_retired", retired, 0);
      chk("midmem_ir", ir, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_fetch", state, 1);
      chk("sb_final", sbq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_22050612_ctrl_fsm.md
# ysyx_22050612_ctrl_fsm

Multi-cycle sequencing controller for the ysyx_22050612 RV64 core. It issues instruction fetches, latches the fetched word for the decoder, and steps the datapath through DECODE, EXEC, optional MEM and WB phases. It generates the register-file and PC write strobes and stops the core on `ebreak`, an illegal encoding or a bus timeout. It sits between the instruction/data bus ports and the IDU/EXU/LSU/register-file datapath.

## Interface
- `TIMEOUT`, 255: maximum wait cycles for any bus ack; range 1..65535.
- `clk` in 1: core clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `inst_ack` in 1: instruction bus ack; `inst_rdata` is valid in the same cycle.
- `inst_rdata` in 32: fetched instruction word.
- `dec_load` in 1: decoder class: load (lw/lbu/ld).
- `dec_store` in 1: decoder class: store (sb/sh/sd).
- `dec_ebreak` in 1: decoder class: ebreak.
- `dec_illegal` in 1: decoder matched no opcode (all opcode fields zero).
- `data_ack` in 1: data bus ack.
- `inst_req` out 1: instruction fetch request.
- `ir` out 32: latched instruction register that drives the IDU.
- `data_req` out 1: data bus request.
- `data_we` out 1: data write; valid while `data_req`=1.
- `reg_we` out 1: register-file write strobe.
- `pc_we` out 1: PC update strobe.
- `halt` out 1: core stopped.
- `halt_code` out 2: 0 none, 1 ebreak, 2 illegal, 3 timeout.
- `retired` out 64: count of retired instructions.
- `state` out 3: current state, for debug and difftest.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE → FETCH unconditionally.
- FETCH: `inst_req`=1. On `inst_ack`, capture `inst_rdata` into `ir` and go to DECODE.
- DECODE: the `dec_*` inputs are sampled here and are a combinational function of `ir`.
  - `dec_ebreak` → HALT, code 1.
  - Otherwise `dec_illegal` → HALT, code 2.
  - Otherwise → EXEC.
- EXEC: always one cycle.
  - `dec_load` or `dec_store` → MEM.
  - Otherwise → WB.
- MEM: `data_req`=1 and `data_we`=`dec_store`. On `data_ack` → WB.
- WB, one cycle:
  - `pc_we`=1.
  - `reg_we`=1 unless the instruction is a store.
  - `retired` increments and wraps at 2^64.
  - Next state FETCH.
- HALT: absorbing state; only `rst_n` exits it. `halt`=1 and `halt_code` holds its value.
- Wait counter (16 bit):
  - Cleared on entry to FETCH or MEM.
  - Increments each cycle the ack is absent.
  - If the count reaches `TIMEOUT` with no ack → HALT, code 3. An ack in that same cycle wins.
- Bus handshake rules:
  - A request stays high until its ack.
  - An ack in the first request cycle is legal.
  - An ack while the matching request is low is ignored.
- `inst_req`, `data_req`, `data_we`, `reg_we`, `pc_we` and `halt` are decoded from `state` only (Moore); they have no combinational path from inputs.

## Timing
- Reset values: state=IDLE, `ir`=0, `retired`=0, `halt_code`=0, wait counter=0. All strobes read 0 in IDLE.
- Minimum latency with ack in the first cycle:
  - ALU instruction: 4 cycles from entering FETCH to leaving WB.
  - Load/store: 5 cycles.
- Cycle after reset release: IDLE. `inst_req` first rises one cycle later.
- `rst_n` asserted mid-instruction (including mid-MEM): immediate return to IDLE. Outstanding bus requests are dropped and the `retired` increment is lost.
- `dec_ebreak` and `dec_illegal` both high: ebreak wins (code 1).
- `dec_load` and `dec_store` both high: treated as a store (`data_we`=1, `reg_we`=0).
- Neither ebreak nor an illegal instruction retires.

## Structure
- Shared package `ysyx_22050612_pkg` holds:
  - the state encoding;
  - the halt-code constants;
  - the `EBREAK` constant 32'h00100073.
- One sub-module, `ysyx_22050612_wait_timer`, contains the clear/increment/expire counter with `TIMEOUT` as its parameter.
- The remainder is a single FSM plus the `ir` and `retired` registers.

## Test plan
- Reset release; `inst_ack` tied high, `inst_rdata`=32'h00100093 (addi). Required response:
  - States IDLE,FETCH,DECODE,EXEC,WB,FETCH.
  - `reg_we`=`pc_we`=1 in WB.
  - `retired`=1.
- Load 32'h0000b083 (ld) with `data_ack` delayed 3 cycles: MEM lasts 4 cycles, `data_we`=0, `reg_we`=1 in WB, `retired` increments by 1.
- Store 32'h0010b023 (sd) with `data_ack` in the first cycle: `data_we`=1, `reg_we`=0 and `pc_we`=1 in WB.
- `inst_rdata`=32'h00100073 (ebreak): `halt`=1 and `halt_code`=1 two cycles after the ack; `retired` unchanged; state stays 6 for 100 cycles.
- `TIMEOUT`=4 with `inst_ack` held low: HALT with `halt_code`=3 after 4 FETCH cycles.
  - Repeat with the ack arriving on the 4th cycle: proceeds to DECODE.
- `rst_n` pulsed low during MEM: `data_req` drops asynchronously, state=IDLE, `retired`=0, `ir`=0.
